instr_stream_encoder: RTL
=========================

// Module: instr_stream_encoder
// PURPOSE
//  Inverse of the instruction decoder: accepts one instruction per handshake
//  as opcode + fields, packs it into the 16-bit ISA word and writes it to
//  instruction memory at consecutive addresses. Sits between the host/loader
//  link and the instruction RAM write port. Tracks word count, full and error.
// PARAMETERS
//  ARQ        16   instruction word width (fixed layout below needs 16)
//  AW         13   instruction-memory address width (same as jump addr field)
//  BASE_ADDR  0    first write address after start
//  DEPTH      8192 max words per program; loader stops when reached
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    pulse: clear counters/flags, begin new program
//  in_valid   in   1    instruction fields valid
//  in_ready   out  1    encoder can accept this cycle
//  in_last    in   1    qualifies final instruction of program
//  opcode     in   3    ISA opcode
//  rd         in   3    dest/srcdest register
//  rs1        in   3    source 1 register
//  rs2        in   3    source 2 register
//  imm        in   10   immediate (I-format)
//  addr       in   13   jump target (J-format)
//  mem_we     out  1    instruction RAM write strobe
//  mem_addr   out  AW   instruction RAM write address
//  mem_wdata  out  ARQ  encoded instruction word
//  count      out  AW+1 words written since start
//  busy       out  1    state == LOAD
//  done       out  1    program complete (last written or DEPTH reached)
//  full       out  1    DEPTH reached before in_last
//  err        out  1    reserved opcode received; sticky until start
// BEHAVIOUR
//  Formats: I [15:13]op [12:10]rd [9:0]imm | R [15:13]op [12:10]rd [9:7]rs1
//   [6:4]rs2 [3:0]=0 | J [15:13]op [12:0]addr. Unused R fields are forced to 0.
//  Opcodes: 000 SET(I) 001 LDPX(R,rd,rs1) 010 MODEX(R) 011 STPX(R,rd,rs1)
//   100 CMPEQ(R, rd forced 0) 101 JMP(J) 110 reserved 111 ADD(I).
//  Reset: state IDLE; in_ready, mem_we, busy, done, full, err = 0;
//   mem_addr = BASE_ADDR; mem_wdata = 0; count = 0.
//  FSM: IDLE -start-> LOAD; LOAD -accepted in_last-> DONE;
//   LOAD -accept making count==DEPTH-> DONE with full=1;
//   LOAD -accepted opcode 110-> ERR. DONE/ERR -start-> LOAD.
//   start in any state aborts: count=0, flags cleared, LOAD next cycle.
//  in_ready = (state==LOAD) && !start. Accept = in_valid && in_ready.
//  Latency: accept at cycle N -> mem_we=1 at N+1, mem_addr=BASE_ADDR+count(N),
//   mem_wdata=encoded word; count increments at N+1. mem_we is 1 cycle/word.
//  mem_addr/mem_wdata hold last value when mem_we=0.
//  Reserved opcode: no write, count unchanged, err=1, in_ready drops at N+1.
//  in_valid outside LOAD is ignored (no write, no error).
//  Address arithmetic mod 2**AW; BASE_ADDR+DEPTH must not exceed 2**AW.
//  done/full/err levels hold until start or reset.
// STRUCTURE
//  Package rsaasip_isa_pkg: opcode enum, format enum, field lsb/msb
//   localparams, OP_RESERVED constant; shared with the decoder.
//  Sub-module instr_encoder: pure combinational fields->word + illegal flag.
//  This module: FSM, address/count registers, output registers.
// TESTING
//  start, SET rd=2 imm=16 -> next cycle mem_we=1, addr 0, wdata 16'h0810.
//  MODEX rd0 rs1 1 rs2 2 then CMPEQ rs1 5 rs2 6 back-to-back -> wdata 16'h40A0
//   at addr 0, 16'h82E0 at addr 1, count=2.
//  JMP addr=4 with in_last -> wdata 16'hA004, done=1, in_ready=0 after.
//  opcode 110 mid-stream -> no mem_we, err=1, count frozen; start clears err.
//  DEPTH=4, 5 valid words no last -> 4 writes, full=1, done=1, 5th not accepted.
//  rst_n low during LOAD with in_valid held -> all outputs to reset values
//   immediately; no write after release until start.

Source files
------------

// File: rtl/rsaasip_isa_pkg.sv
// ISA definitions shared by the instruction decoder and the stream encoder:
// opcodes, instruction formats, field positions and encoder FSM states.
package rsaasip_isa_pkg;

    localparam int ISA_W   = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 0;
    localparam int JA_MSB  = 12;
    localparam int JA_LSB  = 0;

    typedef enum logic [2:0] {
        OP_SET   = 3'b000,
        OP_LDPX  = 3'b001,
        OP_MODEX = 3'b010,
        OP_STPX  = 3'b011,
        OP_CMPEQ = 3'b100,
        OP_JMP   = 3'b101,
        OP_RSVD  = 3'b110,
        OP_ADD   = 3'b111
    } opcode_t;

    localparam logic [2:0] OP_RESERVED = 3'b110;

    typedef enum logic [1:0] {
        FMT_I    = 2'd0,
        FMT_R    = 2'd1,
        FMT_J    = 2'd2,
        FMT_NONE = 2'd3
    } format_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } enc_state_t;

    function automatic format_t op_format(input logic [2:0] op);
        format_t f;
        case (opcode_t'(op))
            OP_SET, OP_ADD:                        f = FMT_I;
            OP_JMP:                                f = FMT_J;
            OP_LDPX, OP_MODEX, OP_STPX, OP_CMPEQ:  f = FMT_R;
            default:                               f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Pure combinational packer: instruction fields -> 16-bit ISA word, plus a
// flag for the reserved opcode. Fields an opcode does not use stay zero.
module instr_encoder
    import rsaasip_isa_pkg::*;
(
    input  logic [2:0]       opcode,
    input  logic [2:0]       rd,
    input  logic [2:0]       rs1,
    input  logic [2:0]       rs2,
    input  logic [9:0]       imm,
    input  logic [12:0]      addr,
    output logic [ISA_W-1:0] word,
    output logic             illegal
);

    always_comb begin
        word    = '0;
        illegal = (opcode == OP_RESERVED);
        word[OP_MSB:OP_LSB] = opcode;
        case (op_format(opcode))
            FMT_I: begin
                word[RD_MSB:RD_LSB]   = rd;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            FMT_J: begin
                word[JA_MSB:JA_LSB] = addr;
            end
            FMT_R: begin
                // CMPEQ has no destination; LDPX/STPX have no second source.
                if (opcode != OP_CMPEQ)
                    word[RD_MSB:RD_LSB] = rd;
                word[RS1_MSB:RS1_LSB] = rs1;
                if (opcode != OP_LDPX && opcode != OP_STPX)
                    word[RS2_MSB:RS2_LSB] = rs2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loader front end: accepts encoded-instruction fields one per handshake and
// writes the packed words to consecutive instruction-RAM addresses.
module instr_stream_encoder
    import rsaasip_isa_pkg::*;
#(
    parameter int ARQ       = 16,
    parameter int AW        = 13,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 8192
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    opcode,
    input  logic [2:0]    rd,
    input  logic [2:0]    rs1,
    input  logic [2:0]    rs2,
    input  logic [9:0]    imm,
    input  logic [AW-1:0] addr,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [ARQ-1:0] mem_wdata,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err,
    output logic [1:0]    dbg_state
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] BASE_W  = AW'(BASE_ADDR);

    // Handshake: a word transfers on a cycle where in_valid and in_ready are
    // both high; in_ready never depends on in_valid, and start blocks accept.
    enc_state_t       state;
    logic [ISA_W-1:0] enc_word;
    logic             enc_illegal;
    logic             accept;
    logic [AW:0]      count_inc;

    assign in_ready  = (state == ST_LOAD) && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + 1'b1;
    assign busy      = (state == ST_LOAD);
    assign dbg_state = state;

    instr_encoder u_enc (
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .addr    (addr),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_W;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state <= ST_LOAD;
                count <= '0;
                done  <= 1'b0;
                full  <= 1'b0;
                err   <= 1'b0;
            end else if (state == ST_LOAD && accept) begin
                if (enc_illegal) begin
                    err   <= 1'b1;
                    state <= ST_ERR;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= BASE_W + count[AW-1:0];
                    mem_wdata <= ARQ'(enc_word);
                    count     <= count_inc;
                    // in_last wins when the last word also fills the program.
                    if (in_last) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (count_inc == DEPTH_W) begin
                        done  <= 1'b1;
                        full  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

endmodule
